// File: rtl/vedic_arb_pkg.sv
// Shared types and widths for the vedic_mul_arbiter slice.
// Optional build macro: VEDIC_ARB_PIPE_EN (adds the CALC2 pipeline state).
package vedic_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping
// modulo NREQ. Produces a one-hot grant, its index and an any-request flag.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any_req
);

  logic [2*NREQ-1:0] rot;

  assign rot = {req, req} >> ptr;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx     = '0;
    any_req = 1'b0;
    // Scan from the far end downward so the position closest to ptr is written last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx     = ID_W'((int'(ptr) + k) % NREQ);
        any_req = 1'b1;
      end
    end
    grant = any_req ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/vedic8x8.sv
// Unsigned 8x8 Vedic (Urdhva-Tiryagbhyam) multiplier built from 2x2 and 4x4 blocks.
// Purely combinational.
module vedic8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
    logic       c;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
    return {4'b0, v2(x[1:0], y[1:0])}
         + {2'b0, v2(x[3:2], y[1:0]), 2'b0}
         + {2'b0, v2(x[1:0], y[3:2]), 2'b0}
         + {v2(x[3:2], y[3:2]), 4'b0};
  endfunction

  assign p = {8'b0, v4(a[3:0], b[3:0])}
           + {4'b0, v4(a[7:4], b[3:0]), 4'b0}
           + {4'b0, v4(a[3:0], b[7:4]), 4'b0}
           + {v4(a[7:4], b[7:4]), 8'b0};

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one vedic8x8 among NREQ requesters, one transaction in flight.
// Optional build macro: VEDIC_ARB_PIPE_EN adds CALC2 and a multiplier output register.
module vedic_mul_arbiter
  import vedic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PROD_W-1:0]    rsp_product,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     win_idx;
  logic                any_req;
  logic [OP_W-1:0]     a_q, b_q;
  logic [PROD_W-1:0]   mul_p;
  logic [OP_W-1:0]     a_arr [NREQ];
  logic [OP_W-1:0]     b_arr [NREQ];
`ifdef VEDIC_ARB_PIPE_EN
  logic [PROD_W-1:0]   p_q;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*OP_W +: OP_W];
    assign b_arr[g] = req_b[g*OP_W +: OP_W];
  end

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  vedic8x8 u_mul (
    .a (a_q),
    .b (b_q),
    .p (mul_p)
  );

  // Grants are only visible in IDLE, so nothing is accepted while a product is in flight.
  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_product <= '0;
      rsp_id      <= '0;
`ifdef VEDIC_ARB_PIPE_EN
      p_q         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a_q    <= a_arr[win_idx];
            b_q    <= b_arr[win_idx];
            rsp_id <= win_idx;
            rr_ptr <= (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
`ifdef VEDIC_ARB_PIPE_EN
          p_q         <= mul_p;
          state       <= CALC2;
`else
          rsp_product <= mul_p;
          state       <= RESP;
`endif
        end
`ifdef VEDIC_ARB_PIPE_EN
        CALC2: begin
          rsp_product <= p_q;
          state       <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
